// File: rtl/slcorem0_wic.sv
// Wake-up interrupt controller: arms on the PMU handshake and
// latches masked IRQ/NMI/RXEV events into sticky pending bits.
module slcorem0_wic #(
  parameter int NUM_IRQ = 32
) (
  input  logic               SYS_FCLK,
  input  logic               SYS_PORESETn,
  input  logic               CORE_WICENREQ,
  output logic               CORE_WICENACK,
  input  logic               CORE_WICLOAD,
  input  logic               CORE_WICCLEAR,
  input  logic [NUM_IRQ+1:0] CORE_WICMASK,
  input  logic [NUM_IRQ+1:0] CORE_WICINT,
  output logic [NUM_IRQ+1:0] CORE_WICSENSE,
  output logic [NUM_IRQ+1:0] CORE_WICPEND,
  output logic               CORE_WAKEUP
);

  localparam int W = NUM_IRQ + 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_WAKE  = 2'd2
  } state_t;

  state_t         r_state;
  logic [W-1:0]   r_mask;
  logic [W-1:0]   r_pend;
  logic           r_ack;
  logic           r_wake;
  logic [W-1:0]   w_pend_nxt;

  // A mask loaded on this edge only qualifies events from the next one.
  assign w_pend_nxt = r_pend | (r_mask & CORE_WICINT);

  always_ff @(posedge SYS_FCLK or negedge SYS_PORESETn) begin
    if (!SYS_PORESETn) begin
      r_state <= S_IDLE;
      r_mask  <= '0;
      r_pend  <= '0;
      r_ack   <= 1'b0;
      r_wake  <= 1'b0;
    end else if (!CORE_WICENREQ) begin
      r_state <= S_IDLE;
      r_mask  <= '0;
      r_pend  <= '0;
      r_ack   <= 1'b0;
      r_wake  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_state <= S_ARMED;
          r_ack   <= 1'b1;
        end
        S_ARMED, S_WAKE: begin
          r_ack <= 1'b1;
          if (CORE_WICCLEAR) begin
            r_state <= S_ARMED;
            r_mask  <= '0;
            r_pend  <= '0;
            r_wake  <= 1'b0;
          end else begin
            if (CORE_WICLOAD)
              r_mask <= CORE_WICMASK;
            r_pend <= w_pend_nxt;
            if (|w_pend_nxt) begin
              r_state <= S_WAKE;
              r_wake  <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_mask  <= '0;
          r_pend  <= '0;
          r_ack   <= 1'b0;
          r_wake  <= 1'b0;
        end
      endcase
    end
  end

  assign CORE_WICENACK = r_ack;
  assign CORE_WAKEUP   = r_wake;
  assign CORE_WICSENSE = r_mask;
  assign CORE_WICPEND  = r_pend;

endmodule
